// File: rtl/change_dispenser_if.sv
// change_dispenser_if: vending-FSM / hopper-side signal bundle for change_dispenser.
// master: the driver of vend/change/eject_ack (vending FSM + hopper model).
// slave:  the change_dispenser itself.
interface change_dispenser_if #(
   parameter int unsigned TOTAL_W = 16
);
   logic               vend;
   logic [2:0]         change;
   logic               eject_ack;
   logic               req_ready;
   logic               eject;
   logic               done;
   logic               busy;
   logic [2:0]         coins_left;
   logic [TOTAL_W-1:0] total_paid;
   logic               fault;

   modport master (
      output vend, change, eject_ack,
      input  req_ready, eject, done, busy, coins_left, total_paid, fault
   );

   modport slave (
      input  vend, change, eject_ack,
      output req_ready, eject, done, busy, coins_left, total_paid, fault
   );
endinterface

// File: rtl/change_dispenser.sv
// change_dispenser: pays change out one 10 rs coin at a time through an eject/eject_ack
// handshake with the coin hopper, tracks coins still owed and a saturating paid-coin total.
// Optional hopper-timeout watchdog (WAIT_ACK timer + sticky FAULT state) is enabled by
// defining CHANGE_DISPENSER_TIMEOUT_EN; without it WAIT_ACK waits forever and fault is 0.
module change_dispenser #(
   parameter int unsigned ACK_TIMEOUT = 15,
   parameter int unsigned EJECT_GAP   = 2,
   parameter int unsigned TOTAL_W     = 16
) (
   input logic               clk,
   input logic               rst,
   change_dispenser_if.slave bus
);

   // Gap counter runs 0 .. EJECT_GAP-1.
   localparam int unsigned      GAP_W     = (EJECT_GAP > 1) ? $clog2(EJECT_GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(EJECT_GAP - 1);
   localparam logic [TOTAL_W-1:0] TOTAL_MAX = {TOTAL_W{1'b1}};

   if (ACK_TIMEOUT < 2 || EJECT_GAP < 1) begin : g_bad_params
      $error("change_dispenser: ACK_TIMEOUT must be >= 2 and EJECT_GAP >= 1");
   end

   typedef enum logic [2:0] {
      StIdle,
      StEject,
      StWaitAck,
      StGap,
      StDone,
      StFault
   } state_e;

   state_e             state_q;
   logic               req_ready_q;
   logic               eject_q;
   logic               done_q;
   logic               busy_q;
   logic               fault_q;
   logic [2:0]         coins_left_q;
   logic [TOTAL_W-1:0] total_paid_q;
   logic [GAP_W-1:0]   gap_cnt_q;

`ifdef CHANGE_DISPENSER_TIMEOUT_EN
   // Timer holds (WAIT_ACK cycle number - 1); last allowed cycle is ACK_TIMEOUT-1.
   localparam int unsigned      TMR_W    = $clog2(ACK_TIMEOUT);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);
   logic [TMR_W-1:0] tmr_q;
`endif

   // Payout FSM; every output is registered and set together with the state it belongs to.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         req_ready_q  <= 1'b1;
         eject_q      <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
         fault_q      <= 1'b0;
         coins_left_q <= 3'd0;
         total_paid_q <= '0;
         gap_cnt_q    <= '0;
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
         tmr_q        <= '0;
`endif
      end else begin
         eject_q <= 1'b0;
         done_q  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.vend) begin
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  if (bus.change != 3'd0) begin
                     coins_left_q <= bus.change;
                     eject_q      <= 1'b1;
                     state_q      <= StEject;
                  end else begin
                     done_q  <= 1'b1;
                     state_q <= StDone;
                  end
               end
            end
            StEject: begin
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
               tmr_q   <= '0;
`endif
               state_q <= StWaitAck;
            end
            StWaitAck: begin
               // An ack in the final allowed cycle takes priority over the timeout.
               if (bus.eject_ack) begin
                  if (coins_left_q != 3'd0) begin
                     coins_left_q <= coins_left_q - 3'd1;
                  end
                  if (total_paid_q != TOTAL_MAX) begin
                     total_paid_q <= total_paid_q + TOTAL_W'(1);
                  end
                  if (coins_left_q == 3'd1) begin
                     done_q  <= 1'b1;
                     state_q <= StDone;
                  end else begin
                     gap_cnt_q <= '0;
                     state_q   <= StGap;
                  end
               end
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
               else if (tmr_q == TMR_LAST) begin
                  busy_q  <= 1'b0;
                  fault_q <= 1'b1;
                  state_q <= StFault;
               end else begin
                  tmr_q <= tmr_q + TMR_W'(1);
               end
`endif
            end
            StGap: begin
               if (gap_cnt_q == GAP_LAST) begin
                  eject_q <= 1'b1;
                  state_q <= StEject;
               end else begin
                  gap_cnt_q <= gap_cnt_q + GAP_W'(1);
               end
            end
            StDone: begin
               busy_q      <= 1'b0;
               req_ready_q <= 1'b1;
               state_q     <= StIdle;
            end
            StFault: begin
               // Sticky: only rst leaves this state.
               state_q <= StFault;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.eject      = eject_q;
   assign bus.done       = done_q;
   assign bus.busy       = busy_q;
   assign bus.fault      = fault_q;
   assign bus.coins_left = coins_left_q;
   assign bus.total_paid = total_paid_q;

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: scoreboard bench for change_dispenser. Stimulus pushes the expected
// eject/done sequence of each payout; a negedge monitor pops and checks it.
module tb_change_dispenser;

   localparam int unsigned TMO = 15;
   localparam int unsigned GAP = 2;

   typedef struct {
      bit              is_done;
      int unsigned     coins;
      longint unsigned total;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   int unsigned     cyc = 0;
   int              errors = 0;
   int              checks = 0;
   exp_t            sb[$];
   exp_t            mon_e;
   longint unsigned model_total = 0;

   change_dispenser_if #(.TOTAL_W(16)) dif ();
   change_dispenser_if #(.TOTAL_W(3))  sif ();

   change_dispenser #(.ACK_TIMEOUT(TMO), .EJECT_GAP(GAP), .TOTAL_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (dif.slave)
   );

   change_dispenser #(.ACK_TIMEOUT(TMO), .EJECT_GAP(GAP), .TOTAL_W(3)) dut_sat (
      .clk (clk),
      .rst (rst),
      .bus (sif.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic longint unsigned sat(input longint unsigned v, input int unsigned w);
      longint unsigned max = (64'd1 << w) - 1;
      return (v > max) ? max : v;
   endfunction

   // Expected outputs of one payout: c ejects counting down, then one done with the new total.
   task automatic push_payout(input int c);
      for (int i = c; i >= 1; i--) sb.push_back(exp_t'{is_done: 1'b0, coins: i, total: 0});
      model_total += longint'(c);
      sb.push_back(exp_t'{is_done: 1'b1, coins: 0, total: sat(model_total, 16)});
   endtask

   always @(negedge clk) begin
      if (!rst && (dif.eject || dif.done)) begin
         check("busy while eject/done", 32'(dif.busy), 1);
         if (sb.size() == 0) begin
            check("unexpected eject/done", {30'd0, dif.eject, dif.done}, 0);
         end else begin
            mon_e = sb.pop_front();
            check("output kind (done)", 32'(dif.done), 32'(mon_e.is_done));
            check("eject and done together", 32'(dif.eject & dif.done), 0);
            if (mon_e.is_done) begin
               check("total_paid at done", 32'(dif.total_paid), 32'(mon_e.total));
               check("coins_left at done", 32'(dif.coins_left), 0);
            end else begin
               check("coins_left at eject", 32'(dif.coins_left), mon_e.coins);
            end
         end
      end
   end

   task automatic check_reset(input string tag);
      check({tag, " req_ready"}, 32'(dif.req_ready), 1);
      check({tag, " eject"}, 32'(dif.eject), 0);
      check({tag, " done"}, 32'(dif.done), 0);
      check({tag, " busy"}, 32'(dif.busy), 0);
      check({tag, " fault"}, 32'(dif.fault), 0);
      check({tag, " coins_left"}, 32'(dif.coins_left), 0);
      check({tag, " total_paid"}, 32'(dif.total_paid), 0);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      dif.vend = 1'b0;
      dif.eject_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      model_total = 0;
      @(negedge clk);
      check_reset(tag);
   endtask

   // Call during an IDLE cycle; returns at the negedge of the cycle after vend was sampled.
   task automatic start_vend(input int c);
      dif.change = 3'(c);
      dif.vend   = 1'b1;
      push_payout(c);
      @(posedge clk);
      #1;
      dif.vend   = 1'b0;
      dif.change = 3'($urandom);
      @(negedge clk);
      check("eject one cycle after vend", 32'(dif.eject), 32'(c != 0));
      check("done one cycle after zero-change vend", 32'(dif.done), 32'(c == 0));
   endtask

   // Call at the negedge of an eject cycle; acks in WAIT_ACK cycle d+1.
   task automatic serve_coin(input int unsigned d, input bit extra, input bit spur_vend);
      repeat (d) @(posedge clk);
      @(posedge clk);
      #1;
      dif.eject_ack = 1'b1;
      if (spur_vend) begin
         dif.vend   = 1'b1;
         dif.change = 3'($urandom);
      end
      @(posedge clk);
      #1;
      dif.eject_ack = extra;  // extra ack lands in GAP and must be ignored
      dif.vend      = 1'b0;
      if (extra) begin
         @(posedge clk);
         #1;
         dif.eject_ack = 1'b0;
      end
   endtask

   task automatic wait_eject(output bit got, output int unsigned at);
      got = 1'b0;
      at  = 0;
      for (int i = 0; i < 64 && !got; i++) begin
         @(negedge clk);
         if (dif.eject) begin
            got = 1'b1;
            at  = cyc;
         end
      end
   endtask

   // Call during an IDLE cycle (negedge); returns at a negedge with req_ready back high.
   task automatic run_payout(input int c, input int unsigned dmin, input int unsigned dmax,
                             input bit spurious);
      int unsigned d;
      int unsigned prev_d;
      int unsigned prev_at;
      int unsigned at;
      bit          got;
      if (spurious && $urandom_range(1, 0) == 1) begin
         dif.eject_ack = 1'b1;
         @(posedge clk);
         #1;
         dif.eject_ack = 1'b0;
      end
      start_vend(c);
      if (c == 0) begin
         @(negedge clk);
         check("req_ready two cycles after zero-change vend", 32'(dif.req_ready), 1);
         check("total_paid unchanged by zero change", 32'(dif.total_paid), 32'(model_total));
         return;
      end
      prev_at = cyc;
      prev_d  = 0;
      for (int k = 0; k < c; k++) begin
         if (k > 0) begin
            wait_eject(got, at);
            check("next eject arrives", 32'(got), 1);
            if (!got) return;
            check("coin period", at - prev_at, GAP + 2 + prev_d);
            prev_at = at;
         end
         d = $urandom_range(dmax, dmin);
         serve_coin(d, spurious && (k != c - 1) && ($urandom_range(1, 0) == 1),
                    spurious && ($urandom_range(1, 0) == 1));
         prev_d = d;
      end
      @(negedge clk);
      check("done after last ack", 32'(dif.done), 1);
      @(negedge clk);
      check("req_ready after done", 32'(dif.req_ready), 1);
   endtask

   initial begin
      bit              got;
      int unsigned     at;
      longint unsigned paid_before;

      dif.vend = 1'b0;
      dif.change = 3'd0;
      dif.eject_ack = 1'b0;
      sif.vend = 1'b0;
      sif.change = 3'd0;
      sif.eject_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_reset("after reset");

      // Four coins, ack in the first WAIT_ACK cycle each time.
      run_payout(4, 0, 0, 1'b0);
      check("total_paid after change=4", 32'(dif.total_paid), 4);

      // Zero change: done only.
      run_payout(0, 0, 0, 1'b0);

      paid_before = model_total;
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
      start_vend(2);
      repeat (TMO) @(negedge clk);
      check("no fault in last allowed WAIT_ACK cycle", 32'(dif.fault), 0);
      check("busy while waiting for ack", 32'(dif.busy), 1);
      @(negedge clk);
      check("fault after timeout", 32'(dif.fault), 1);
      check("busy low in fault", 32'(dif.busy), 0);
      check("req_ready low in fault", 32'(dif.req_ready), 0);
      check("coins_left held in fault", 32'(dif.coins_left), 2);
      dif.vend = 1'b1;
      dif.change = 3'd3;
      dif.eject_ack = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      dif.vend = 1'b0;
      dif.eject_ack = 1'b0;
      @(negedge clk);
      check("fault sticky", 32'(dif.fault), 1);
      check("coins_left unchanged by inputs in fault", 32'(dif.coins_left), 2);
      check("total_paid unchanged in fault", 32'(dif.total_paid), 32'(paid_before));
      do_reset("after fault reset");
      // Ack in the final allowed cycle wins.
      run_payout(2, TMO - 1, TMO - 1, 1'b0);
      check("no fault when ack in last cycle", 32'(dif.fault), 0);
`else
      start_vend(2);
      repeat (40) @(negedge clk);
      check("no fault while ack withheld", 32'(dif.fault), 0);
      check("still busy while ack withheld", 32'(dif.busy), 1);
      check("coins_left while ack withheld", 32'(dif.coins_left), 2);
      serve_coin(0, 1'b0, 1'b0);
      wait_eject(got, at);
      check("second eject after late ack", 32'(got), 1);
      serve_coin(0, 1'b0, 1'b0);
      @(negedge clk);
      check("done after late-ack payout", 32'(dif.done), 1);
      @(negedge clk);
      check("total_paid after late-ack payout", 32'(dif.total_paid), 32'(paid_before + 2));
`endif

      // Reset during WAIT_ACK of the second coin of five.
      start_vend(5);
      serve_coin(0, 1'b0, 1'b0);
      wait_eject(got, at);
      check("second eject of five", 32'(got), 1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      model_total = 0;
      @(negedge clk);
      check_reset("after mid-payout reset");

      // Randomised payouts with spurious acks and vends.
      for (int t = 0; t < 25; t++) run_payout(int'($urandom_range(7, 0)), 0, 3, 1'b1);
      check("total_paid after random payouts", 32'(dif.total_paid), 32'(model_total));
      check("fault never raised", 32'(dif.fault), 0);

      // Saturation on the 3-bit counter instance.
      for (int i = 0; i < 8; i++) begin
         sif.change = 3'd1;
         sif.vend = 1'b1;
         @(posedge clk);
         #1;
         sif.vend = 1'b0;
         @(negedge clk);
         check("sat: eject", 32'(sif.eject), 1);
         @(posedge clk);
         #1;
         sif.eject_ack = 1'b1;
         @(posedge clk);
         #1;
         sif.eject_ack = 1'b0;
         @(negedge clk);
         check("sat: done", 32'(sif.done), 1);
         check("sat: total_paid", 32'(sif.total_paid), 32'(sat(longint'(i + 1), 3)));
         @(negedge clk);
         check("sat: req_ready", 32'(sif.req_ready), 1);
      end

      check("scoreboard drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
